// File: rtl/bp_cce_cmd_burst_tx.sv
// bp_cce_cmd_burst_tx
//  CCE-side transmitter for the BedRock LCE command channel in burst form.
//  It accepts one whole command (header plus a full cache block) and sends
//  it as one header beat followed by dword-wide data beats. lce_cmd_last_o
//  marks the final beat. Only one message is in flight at a time.
//  Optional feature macro: BP_CCE_CMD_TX_CWF_EN. When it is defined, the
//  data beats leave critical-dword-first and wrap around the block.
module bp_cce_cmd_burst_tx #(
  parameter int unsigned header_width_p = 64,
  parameter int unsigned block_width_p  = 512,
  parameter int unsigned dword_width_p  = 64,
  localparam int unsigned beats_lp      = block_width_p / dword_width_p,
  localparam int unsigned idx_w_lp      = (beats_lp > 1) ? $clog2(beats_lp) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,

  input  logic [header_width_p-1:0] cmd_header_i,
  input  logic                      cmd_has_data_i,
  input  logic [block_width_p-1:0]  cmd_data_i,
  input  logic [idx_w_lp-1:0]       cmd_crit_idx_i,
  input  logic                      cmd_v_i,
  output logic                      cmd_ready_and_o,

  output logic [header_width_p-1:0] lce_cmd_header_o,
  output logic                      lce_cmd_header_v_o,
  input  logic                      lce_cmd_header_ready_and_i,
  output logic [dword_width_p-1:0]  lce_cmd_data_o,
  output logic                      lce_cmd_data_v_o,
  input  logic                      lce_cmd_data_ready_and_i,
  output logic                      lce_cmd_last_o
);

  localparam logic [idx_w_lp-1:0] last_beat_lp = idx_w_lp'(beats_lp - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } state_e;

  state_e                                 state_r, state_n;
  logic   [idx_w_lp-1:0]                  beat_cnt_r, beat_cnt_n;
  logic   [idx_w_lp-1:0]                  data_idx_n;
  logic                                   has_data_r, has_data_n;
  logic                                   accept;
  logic                                   last_n;
  logic   [beats_lp-1:0][dword_width_p-1:0] data_r;

`ifdef BP_CCE_CMD_TX_CWF_EN
  logic [idx_w_lp-1:0] start_r;

  // Critical dword index captured with the command; beats are sent starting there.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      start_r <= cmd_crit_idx_i;
    end
  end

  assign data_idx_n = start_r + beat_cnt_n;
`else
  logic crit_idx_unused;

  // Beats always start at dword 0, so the critical index is not needed.
  assign crit_idx_unused = ^cmd_crit_idx_i;
  assign data_idx_n      = beat_cnt_n;
`endif

  // Next-state logic and the next values of the registered outputs.
  always_comb begin
    state_n    = state_r;
    beat_cnt_n = beat_cnt_r;
    accept     = 1'b0;

    case (state_r)
      IDLE: begin
        if (cmd_v_i) begin
          accept  = 1'b1;
          state_n = HEADER;
        end
      end
      HEADER: begin
        if (lce_cmd_header_ready_and_i) begin
          beat_cnt_n = '0;
          state_n    = has_data_r ? DATA : IDLE;
        end
      end
      DATA: begin
        if (lce_cmd_data_ready_and_i) begin
          if (beat_cnt_r == last_beat_lp) begin
            beat_cnt_n = '0;
            state_n    = IDLE;
          end else begin
            beat_cnt_n = beat_cnt_r + 1'b1;
          end
        end
      end
      default: begin
        state_n    = IDLE;
        beat_cnt_n = '0;
      end
    endcase

    has_data_n = accept ? cmd_has_data_i : has_data_r;
    last_n     = ((state_n == HEADER) && !has_data_n)
              || ((state_n == DATA) && (beat_cnt_n == last_beat_lp));
  end

  // Control state and handshake outputs; reset drops any message in flight.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r            <= IDLE;
      beat_cnt_r         <= '0;
      has_data_r         <= 1'b0;
      cmd_ready_and_o    <= 1'b1;
      lce_cmd_header_v_o <= 1'b0;
      lce_cmd_data_v_o   <= 1'b0;
      lce_cmd_last_o     <= 1'b0;
    end else begin
      state_r            <= state_n;
      beat_cnt_r         <= beat_cnt_n;
      has_data_r         <= has_data_n;
      cmd_ready_and_o    <= (state_n == IDLE);
      lce_cmd_header_v_o <= (state_n == HEADER);
      lce_cmd_data_v_o   <= (state_n == DATA);
      lce_cmd_last_o     <= last_n;
    end
  end

  // Payload registers: the header and block are held for the whole message, and the beat follows the next index.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lce_cmd_header_o <= cmd_header_i;
      data_r           <= cmd_data_i;
    end
    lce_cmd_data_o <= data_r[data_idx_n];
  end

endmodule

// File: tb/tb_bp_cce_cmd_burst_tx.sv
// tb_bp_cce_cmd_burst_tx
//  Random and directed bench for bp_cce_cmd_burst_tx. A queue of expected
//  beats is built for every accepted command and compared each cycle.
//  The BP_CCE_CMD_TX_CWF_EN macro selects the same build as the RTL.
module tb_bp_cce_cmd_burst_tx;

  localparam int unsigned HW    = 64;
  localparam int unsigned BW    = 512;
  localparam int unsigned DW    = 64;
  localparam int unsigned BEATS = BW / DW;

  logic          clk;
  logic          reset_n;
  logic [HW-1:0] cmd_header;
  logic          cmd_has_data;
  logic [BW-1:0] cmd_data;
  logic [2:0]    cmd_crit_idx;
  logic          cmd_v;
  logic          cmd_ready;
  logic [HW-1:0] hdr_o;
  logic          hdr_v;
  logic          hdr_rdy;
  logic [DW-1:0] data_o;
  logic          data_v;
  logic          data_rdy;
  logic          last_o;

  typedef struct {
    bit            is_hdr;
    logic [63:0]   val;
    bit            last;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  bp_cce_cmd_burst_tx #(
    .header_width_p(HW),
    .block_width_p (BW),
    .dword_width_p (DW)
  ) dut (
    .clk_i                     (clk),
    .reset_n_i                 (reset_n),
    .cmd_header_i              (cmd_header),
    .cmd_has_data_i            (cmd_has_data),
    .cmd_data_i                (cmd_data),
    .cmd_crit_idx_i            (cmd_crit_idx),
    .cmd_v_i                   (cmd_v),
    .cmd_ready_and_o           (cmd_ready),
    .lce_cmd_header_o          (hdr_o),
    .lce_cmd_header_v_o        (hdr_v),
    .lce_cmd_header_ready_and_i(hdr_rdy),
    .lce_cmd_data_o            (data_o),
    .lce_cmd_data_v_o          (data_v),
    .lce_cmd_data_ready_and_i  (data_rdy),
    .lce_cmd_last_o            (last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected beat sequence for one command, taken from the message format rules.
  task automatic push_cmd(input logic [HW-1:0] hdr, input bit hd, input logic [BW-1:0] d,
                          input logic [2:0] crit);
    beat_t b;
    int    start;
    int    idx;
    b.is_hdr = 1'b1;
    b.val    = hdr;
    b.last   = !hd;
    exp_q.push_back(b);
    if (hd) begin
`ifdef BP_CCE_CMD_TX_CWF_EN
      start = int'(crit);
`else
      start = 0;
`endif
      for (int k = 0; k < BEATS; k++) begin
        idx      = (start + k) % BEATS;
        b.is_hdr = 1'b0;
        b.val    = d[idx*DW +: DW];
        b.last   = (k == BEATS - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  // One cycle: check the outputs at negedge, then drive the inputs and update the model.
  task automatic step(input bit v, input bit hd, input logic [BW-1:0] d, input logic [2:0] crit,
                      input bit hr, input bit dr, input logic [HW-1:0] hdr);
    bit    busy;
    beat_t f;
    @(negedge clk);
    busy = (exp_q.size() != 0);
    check_val("cmd_ready", 64'(cmd_ready), 64'(!busy));
    if (busy) begin
      f = exp_q[0];
      check_val("header_v", 64'(hdr_v), 64'(f.is_hdr));
      check_val("data_v", 64'(data_v), 64'(!f.is_hdr));
      check_val("last", 64'(last_o), 64'(f.last));
      if (f.is_hdr) check_val("header", hdr_o, f.val);
      else          check_val("data", data_o, f.val);
    end else begin
      check_val("idle_header_v", 64'(hdr_v), 64'd0);
      check_val("idle_data_v", 64'(data_v), 64'd0);
      check_val("idle_last", 64'(last_o), 64'd0);
    end
    cmd_v        = v;
    cmd_has_data = hd;
    cmd_data     = d;
    cmd_crit_idx = crit;
    hdr_rdy      = hr;
    data_rdy     = dr;
    cmd_header   = hdr;
    if (busy) begin
      if (f.is_hdr ? hr : dr) void'(exp_q.pop_front());
    end else if (v) begin
      push_cmd(hdr, hd, d, crit);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * BEATS + 4; i++) begin
      step(1'b0, 1'b0, '0, 3'd0, 1'b1, 1'b1, '0);
      if (exp_q.size() == 0) break;
    end
    step(1'b0, 1'b0, '0, 3'd0, 1'b1, 1'b1, '0);
  endtask

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] r;
    for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [HW-1:0] rand_hdr();
    return {$urandom, $urandom};
  endfunction

  logic [BW-1:0] dk;
  int            stall;

  initial begin
    reset_n      = 1'b0;
    cmd_v        = 1'b0;
    cmd_has_data = 1'b0;
    cmd_data     = '0;
    cmd_crit_idx = '0;
    cmd_header   = '0;
    hdr_rdy      = 1'b1;
    data_rdy     = 1'b1;
    for (int k = 0; k < BEATS; k++) dk[k*DW +: DW] = 64'(k);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ready", 64'(cmd_ready), 64'd1);
    check_val("rst_header_v", 64'(hdr_v), 64'd0);
    check_val("rst_data_v", 64'(data_v), 64'd0);
    check_val("rst_last", 64'(last_o), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Header-only message
    step(1'b1, 1'b0, '0, 3'd0, 1'b1, 1'b1, 64'hA5A5_0001_DEAD_BEEF);
    drain();

    // Data message, dword k = k
    step(1'b1, 1'b1, dk, 3'd0, 1'b1, 1'b1, 64'h0000_0002_0000_0002);
    drain();

    // Backpressure on beat 4 for three cycles
    step(1'b1, 1'b1, rand_block(), 3'd0, 1'b1, 1'b1, rand_hdr());
    stall = 0;
    for (int i = 0; i < 3 * BEATS; i++) begin
      if (exp_q.size() == 0) break;
      if (exp_q.size() == 4 && stall < 3) begin
        stall++;
        step(1'b0, 1'b0, '0, 3'd0, 1'b1, 1'b0, '0);
      end else begin
        step(1'b0, 1'b0, '0, 3'd0, 1'b1, 1'b1, '0);
      end
    end
    drain();

    // Critical-dword index 5
    step(1'b1, 1'b1, dk, 3'd5, 1'b1, 1'b1, 64'h0000_0004_0000_0005);
    drain();

    // Reset asserted while beat 3 is on the bus
    step(1'b1, 1'b1, rand_block(), 3'($urandom_range(0, 7)), 1'b1, 1'b1, rand_hdr());
    for (int i = 0; i < 3 * BEATS; i++) begin
      if (exp_q.size() == 5) break;
      step(1'b0, 1'b0, '0, 3'd0, 1'b1, 1'b1, '0);
    end
    @(posedge clk);
    #2;
    check_val("pre_rst_data_v", 64'(data_v), 64'd1);
    reset_n = 1'b0;
    #1;
    check_val("arst_data_v", 64'(data_v), 64'd0);
    check_val("arst_header_v", 64'(hdr_v), 64'd0);
    check_val("arst_last", 64'(last_o), 64'd0);
    check_val("arst_ready", 64'(cmd_ready), 64'd1);
    exp_q.delete();
    step(1'b0, 1'b0, '0, 3'd0, 1'b1, 1'b1, '0);
    step(1'b0, 1'b0, '0, 3'd0, 1'b1, 1'b1, '0);
    reset_n = 1'b1;
    step(1'b1, 1'b1, dk, 3'd2, 1'b1, 1'b1, rand_hdr());
    drain();

    // cmd_v held high across several messages
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'(i % 3 != 0), rand_block(), 3'($urandom_range(0, 7)), 1'b1, 1'b1, 64'(i + 100));
    end
    drain();

    // Random traffic with random backpressure
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rand_block(),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7),
           rand_hdr());
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
